// File: rtl/tcp_tx_retransmit_buffer.sv
// TCP transmit-side retransmit buffer: stores application bytes by sequence number,
// cuts MSS/window-limited segments, frees space on ACK and goes back to snd_una on RTO.
module tcp_tx_retransmit_buffer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned SEQ_BITS   = 32,
   parameter int unsigned MSS        = 16,
   parameter int unsigned RTO_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   input  logic [SEQ_BITS-1:0]   seq_init,
   input  logic                  init_valid,
   input  logic [SEQ_BITS-1:0]   ack_in,
   input  logic                  ack_valid,
   input  logic [31:0]           peer_window,
   output logic [SEQ_BITS-1:0]   seg_seq,
   output logic [SEQ_BITS-1:0]   snd_una,
   output logic [SEQ_BITS-1:0]   snd_nxt,
   output logic [31:0]           free_bytes,
   output logic [15:0]           retx_count
);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned AW = (SEQ_BITS > 32) ? SEQ_BITS : 32;
   localparam int unsigned LW = $clog2(MSS + 1);
   localparam int unsigned TW = $clog2(RTO_CYCLES + 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state_q, state_d;
   logic                  init_q, init_d;
   logic [SEQ_BITS-1:0]   wr_seq_q, wr_seq_d, snd_una_q, snd_una_d, snd_nxt_q, snd_nxt_d;
   logic [SEQ_BITS-1:0]   seg_seq_q, seg_seq_d;
   logic [LW-1:0]         seg_left_q, seg_left_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [15:0]           retx_q, retx_d;
   logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;

   logic [DATA_WIDTH:0]   mem_q [DEPTH];
   logic [SEQ_BITS-1:0]   inflight_s, pending_s, used_s, ack_delta;
   logic [AW-1:0]         inflight, pending, wavail, seg_len;
   logic [IW-1:0]         rd_idx;
   logic                  rd_last, wr_en, ack_ok, win_ok, expire;
   logic [DATA_WIDTH-1:0] rd_data;

   assign inflight_s = snd_nxt_q - snd_una_q;
   assign pending_s  = wr_seq_q - snd_nxt_q;
   assign used_s     = wr_seq_q - snd_una_q;
   assign ack_delta  = ack_in - snd_una_q;
   assign inflight   = AW'(inflight_s);
   assign pending    = AW'(pending_s);
   assign wavail     = AW'(peer_window) - inflight;

   assign free_bytes    = 32'(AW'(DEPTH) - AW'(used_s));
   assign s_axis_tready = init_q && (free_bytes != 32'd0);
   assign wr_en         = s_axis_tvalid && s_axis_tready && !init_valid;
   assign ack_ok        = ack_valid && (ack_delta != '0) && (ack_delta <= inflight_s);
   assign win_ok        = inflight < AW'(peer_window);
   assign expire        = (state_q == IDLE) && (inflight_s != '0) && !ack_ok &&
                          (timer_q == TW'(RTO_CYCLES));

   // In IDLE the first byte of a new segment is fetched, in SEND the one after the current.
   assign rd_idx  = (state_q == SEND) ? IW'(snd_nxt_q + SEQ_BITS'(1)) : IW'(snd_nxt_q);
   assign rd_data = mem_q[rd_idx][DATA_WIDTH-1:0];
   assign rd_last = mem_q[rd_idx][DATA_WIDTH];

   always_comb begin
      seg_len = AW'(MSS);
      if (pending < seg_len) seg_len = pending;
      if (wavail < seg_len)  seg_len = wavail;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[IW'(wr_seq_q)] <= {s_axis_tlast, s_axis_tdata};
   end

   always_comb begin
      state_d    = state_q;
      init_d     = init_q;
      wr_seq_d   = wr_seq_q;
      snd_una_d  = snd_una_q;
      snd_nxt_d  = snd_nxt_q;
      seg_seq_d  = seg_seq_q;
      seg_left_d = seg_left_q;
      timer_d    = timer_q;
      retx_d     = retx_q;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;
      tdata_d    = tdata_q;

      if (wr_en)  wr_seq_d  = wr_seq_q + SEQ_BITS'(1);
      if (ack_ok) snd_una_d = ack_in;

      case (state_q)
         IDLE: begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (expire) begin
               snd_nxt_d = snd_una_q;
               if (retx_q != 16'hFFFF) retx_d = retx_q + 16'd1;
            end else if (init_q && (pending != '0) && win_ok) begin
               state_d    = SEND;
               seg_seq_d  = snd_nxt_q;
               seg_left_d = LW'(seg_len);
               tvalid_d   = 1'b1;
               tdata_d    = rd_data;
               tlast_d    = rd_last || (seg_len == AW'(1));
            end
         end
         SEND: begin
            if (tvalid_q && m_axis_tready) begin
               snd_nxt_d = snd_nxt_q + SEQ_BITS'(1);
               if (tlast_q) begin
                  state_d  = IDLE;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
               end else begin
                  seg_left_d = seg_left_q - LW'(1);
                  tdata_d    = rd_data;
                  tlast_d    = rd_last || (seg_left_q == LW'(2));
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Retransmit timer only runs while unacknowledged bytes are outstanding.
      if (ack_ok || (inflight_s == '0) || expire) timer_d = '0;
      else if (timer_q != TW'(RTO_CYCLES))        timer_d = timer_q + TW'(1);

      if (init_valid) begin
         init_d    = 1'b1;
         wr_seq_d  = seq_init;
         snd_una_d = seq_init;
         snd_nxt_d = seq_init;
         timer_d   = '0;
         state_d   = IDLE;
         tvalid_d  = 1'b0;
         tlast_d   = 1'b0;
         retx_d    = retx_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         init_q     <= 1'b0;
         wr_seq_q   <= '0;
         snd_una_q  <= '0;
         snd_nxt_q  <= '0;
         seg_seq_q  <= '0;
         seg_left_q <= '0;
         timer_q    <= '0;
         retx_q     <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         init_q     <= init_d;
         wr_seq_q   <= wr_seq_d;
         snd_una_q  <= snd_una_d;
         snd_nxt_q  <= snd_nxt_d;
         seg_seq_q  <= seg_seq_d;
         seg_left_q <= seg_left_d;
         timer_q    <= timer_d;
         retx_q     <= retx_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tdata_q    <= tdata_d;
      end
   end

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tdata  = tdata_q;
   assign seg_seq       = seg_seq_q;
   assign snd_una       = snd_una_q;
   assign snd_nxt       = snd_nxt_q;
   assign retx_count    = retx_q;
endmodule

// File: tb/tb_tcp_tx_retransmit_buffer.sv
// Directed bench for tcp_tx_retransmit_buffer: segmentation, flow control, ACK, RTO, wrap, stall.
`timescale 1ns/1ps
module tb_tcp_tx_retransmit_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0;
   logic        s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tlast;
   logic        m_tready = 1'b0;
   logic [31:0] seq_init = '0, ack_in = '0, peer_window = '0;
   logic        init_valid = 1'b0, ack_valid = 1'b0;
   logic [31:0] seg_seq, snd_una, snd_nxt, free_bytes;
   logic [15:0] retx_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  q_data[$];
   bit          q_last[$];
   logic [31:0] q_seq[$];

   tcp_tx_retransmit_buffer dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .seq_init(seq_init), .init_valid(init_valid), .ack_in(ack_in), .ack_valid(ack_valid),
      .peer_window(peer_window), .seg_seq(seg_seq), .snd_una(snd_una), .snd_nxt(snd_nxt),
      .free_bytes(free_bytes), .retx_count(retx_count)
   );

   always #5 clk = ~clk;

   // Record every output handshake; inputs change just after posedge, so negedge sees the pending beat.
   always @(negedge clk) begin
      if (!rst && m_tvalid && m_tready) begin
         q_data.push_back(m_tdata);
         q_last.push_back(m_tlast);
         q_seq.push_back(seg_seq);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_init(input logic [31:0] isn);
      seq_init = isn; init_valid = 1'b1;
      step();
      init_valid = 1'b0;
      q_data.delete(); q_last.delete(); q_seq.delete();
   endtask

   task automatic do_ack(input logic [31:0] a);
      ack_in = a; ack_valid = 1'b1;
      step();
      ack_valid = 1'b0;
   endtask

   task automatic push(input int n, input logic [7:0] base, input int last_at, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         int b;
         b = 0;
         s_tdata = base + 8'(i); s_tlast = (i == last_at); s_tvalid = 1'b1;
         @(negedge clk);
         while (!s_tready && b < 200) begin @(negedge clk); b++; end
         if (!s_tready) ok = 1'b0;
         step();
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         step();
         if (q_data.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
      n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
      n_cmp++; if (m_tdata !== 8'h00) begin n_bad++; $display("FAIL rst_tdata: got %h want 00", m_tdata); end
      n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %b want 0", s_tready); end
      n_cmp++; if (seg_seq !== 32'd0) begin n_bad++; $display("FAIL rst_seg_seq: got %0d want 0", seg_seq); end
      n_cmp++; if (snd_una !== 32'd0) begin n_bad++; $display("FAIL rst_snd_una: got %0d want 0", snd_una); end
      n_cmp++; if (snd_nxt !== 32'd0) begin n_bad++; $display("FAIL rst_snd_nxt: got %0d want 0", snd_nxt); end
      n_cmp++; if (free_bytes !== 32'd64) begin n_bad++; $display("FAIL rst_free: got %0d want 64", free_bytes); end
      n_cmp++; if (retx_count !== 16'd0) begin n_bad++; $display("FAIL rst_retx: got %0d want 0", retx_count); end
      @(posedge clk); #1; rst = 1'b0;
      step();
      n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL uninit_tready: got %b want 0", s_tready); end
   endtask

   task automatic test_segmentation();
      bit ok;
      logic [31:0] exp_seq;
      bit exp_last;
      m_tready = 1'b1; peer_window = 32'd0;
      do_init(32'd1000);
      push(20, 8'h00, -1, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL seg_push: tready stuck low"); end
      peer_window = 32'd1000;
      wait_bytes(20, 100, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL seg_count: got %0d bytes want 20", q_data.size()); end
      for (int i = 0; i < 20 && i < q_data.size(); i++) begin
         exp_seq = (i < 16) ? 32'd1000 : 32'd1016;
         exp_last = (i == 15) || (i == 19);
         n_cmp++;
         if (q_data[i] !== 8'(i) || q_last[i] !== exp_last || q_seq[i] !== exp_seq) begin
            n_bad++;
            $display("FAIL seg_byte%0d: got d=%h l=%b s=%0d want d=%h l=%b s=%0d",
                     i, q_data[i], q_last[i], q_seq[i], 8'(i), exp_last, exp_seq);
         end
      end
      step(); step();
      n_cmp++; if (snd_nxt !== 32'd1020) begin n_bad++; $display("FAIL seg_snd_nxt: got %0d want 1020", snd_nxt); end
      n_cmp++; if (snd_una !== 32'd1000) begin n_bad++; $display("FAIL seg_snd_una: got %0d want 1000", snd_una); end
      n_cmp++; if (free_bytes !== 32'd44) begin n_bad++; $display("FAIL seg_free: got %0d want 44", free_bytes); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL seg_idle: got tvalid %b want 0", m_tvalid); end
   endtask

   task automatic test_full_ack();
      bit ok;
      m_tready = 1'b1; peer_window = 32'd1000;
      do_init(32'd2000);
      push(64, 8'h80, -1, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_push: tready stuck low"); end
      wait_bytes(64, 300, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_count: got %0d bytes want 64", q_data.size()); end
      step();
      n_cmp++; if (free_bytes !== 32'd0) begin n_bad++; $display("FAIL full_free: got %0d want 0", free_bytes); end
      n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL full_tready: got %b want 0", s_tready); end
      n_cmp++; if (snd_nxt !== 32'd2064) begin n_bad++; $display("FAIL full_snd_nxt: got %0d want 2064", snd_nxt); end
      do_ack(32'd2010);
      n_cmp++; if (snd_una !== 32'd2010) begin n_bad++; $display("FAIL ack_snd_una: got %0d want 2010", snd_una); end
      n_cmp++; if (free_bytes !== 32'd10) begin n_bad++; $display("FAIL ack_free: got %0d want 10", free_bytes); end
      n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL ack_tready: got %b want 1", s_tready); end
   endtask

   task automatic test_retransmit();
      bit ok;
      m_tready = 1'b1; peer_window = 32'd0;
      do_init(32'd3000);
      push(8, 8'hA0, -1, ok);
      peer_window = 32'd1000;
      wait_bytes(8, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rto_first_count: got %0d want 8", q_data.size()); end
      step();
      n_cmp++; if (snd_nxt !== 32'd3008) begin n_bad++; $display("FAIL rto_snd_nxt_sent: got %0d want 3008", snd_nxt); end
      q_data.delete(); q_last.delete(); q_seq.delete();
      ok = 1'b0;
      for (int c = 0; c < 1200; c++) begin
         step();
         if (retx_count != 16'd0) begin ok = 1'b1; break; end
      end
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rto_timeout: retx_count never moved"); end
      n_cmp++; if (retx_count !== 16'd1) begin n_bad++; $display("FAIL rto_retx: got %0d want 1", retx_count); end
      n_cmp++; if (snd_nxt !== 32'd3000) begin n_bad++; $display("FAIL rto_rewind: got %0d want 3000", snd_nxt); end
      wait_bytes(8, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rto_resend_count: got %0d want 8", q_data.size()); end
      for (int i = 0; i < 8 && i < q_data.size(); i++) begin
         n_cmp++;
         if (q_data[i] !== 8'hA0 + 8'(i) || q_last[i] !== (i == 7) || q_seq[i] !== 32'd3000) begin
            n_bad++;
            $display("FAIL rto_byte%0d: got d=%h l=%b s=%0d want d=%h l=%b s=3000",
                     i, q_data[i], q_last[i], q_seq[i], 8'hA0 + 8'(i), (i == 7));
         end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      m_tready = 1'b1; peer_window = 32'd0;
      do_init(32'hFFFF_FFF8);
      push(16, 8'h10, -1, ok);
      peer_window = 32'd1000;
      wait_bytes(16, 60, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_count: got %0d want 16", q_data.size()); end
      for (int i = 0; i < 16 && i < q_data.size(); i++) begin
         n_cmp++;
         if (q_data[i] !== 8'h10 + 8'(i) || q_last[i] !== (i == 15) || q_seq[i] !== 32'hFFFF_FFF8) begin
            n_bad++;
            $display("FAIL wrap_byte%0d: got d=%h l=%b s=%h want d=%h l=%b s=fffffff8",
                     i, q_data[i], q_last[i], q_seq[i], 8'h10 + 8'(i), (i == 15));
         end
      end
      step();
      n_cmp++; if (snd_nxt !== 32'h8) begin n_bad++; $display("FAIL wrap_snd_nxt: got %h want 8", snd_nxt); end
      do_ack(32'h4);
      n_cmp++; if (snd_una !== 32'h4) begin n_bad++; $display("FAIL wrap_ack_ok: got %h want 4", snd_una); end
      n_cmp++; if (free_bytes !== 32'd60) begin n_bad++; $display("FAIL wrap_free: got %0d want 60", free_bytes); end
      do_ack(32'h20);
      n_cmp++; if (snd_una !== 32'h4) begin n_bad++; $display("FAIL wrap_ack_ignored: got %h want 4", snd_una); end
   endtask

   task automatic test_window_tlast();
      bit ok;
      logic [31:0] exp_seq;
      m_tready = 1'b1; peer_window = 32'd0;
      do_init(32'd5000);
      push(10, 8'h50, -1, ok);
      peer_window = 32'd3;
      wait_bytes(3, 30, ok);
      repeat (20) step();
      n_cmp++; if (q_data.size() != 3) begin n_bad++; $display("FAIL win_count: got %0d want 3", q_data.size()); end
      n_cmp++; if (snd_nxt !== 32'd5003) begin n_bad++; $display("FAIL win_snd_nxt: got %0d want 5003", snd_nxt); end
      do_ack(32'd5003);
      wait_bytes(6, 30, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL win_reopen: got %0d bytes want 6", q_data.size()); end
      for (int i = 0; i < 6 && i < q_data.size(); i++) begin
         exp_seq = (i < 3) ? 32'd5000 : 32'd5003;
         n_cmp++;
         if (q_data[i] !== 8'h50 + 8'(i) || q_last[i] !== (i == 2 || i == 5) || q_seq[i] !== exp_seq) begin
            n_bad++;
            $display("FAIL win_byte%0d: got d=%h l=%b s=%0d want d=%h l=%b s=%0d",
                     i, q_data[i], q_last[i], q_seq[i], 8'h50 + 8'(i), (i == 2 || i == 5), exp_seq);
         end
      end
      peer_window = 32'd0;
      do_init(32'd6000);
      push(6, 8'h60, 1, ok);
      peer_window = 32'd1000;
      wait_bytes(6, 40, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tlast_count: got %0d want 6", q_data.size()); end
      for (int i = 0; i < 6 && i < q_data.size(); i++) begin
         exp_seq = (i < 2) ? 32'd6000 : 32'd6002;
         n_cmp++;
         if (q_data[i] !== 8'h60 + 8'(i) || q_last[i] !== (i == 1 || i == 5) || q_seq[i] !== exp_seq) begin
            n_bad++;
            $display("FAIL tlast_byte%0d: got d=%h l=%b s=%0d want d=%h l=%b s=%0d",
                     i, q_data[i], q_last[i], q_seq[i], 8'h60 + 8'(i), (i == 1 || i == 5), exp_seq);
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      bit have_prev, pv, pr, pl;
      logic [7:0] pd;
      logic [31:0] exp_seq;
      m_tready = 1'b0; peer_window = 32'd0;
      do_init(32'd7000);
      push(40, 8'h40, -1, ok);
      peer_window = 32'd1000;
      have_prev = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
      ok = 1'b0;
      for (int c = 0; c < 600; c++) begin
         step();
         if (q_data.size() >= 40) begin ok = 1'b1; break; end
         m_tready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (have_prev && pv && !pr) begin
            n_cmp++;
            if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl) begin
               n_bad++;
               $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", m_tvalid, m_tdata, m_tlast, pd, pl);
            end
         end
         have_prev = 1'b1; pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
      end
      m_tready = 1'b1;
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_count: got %0d want 40", q_data.size()); end
      for (int i = 0; i < 40 && i < q_data.size(); i++) begin
         exp_seq = 32'd7000 + 32'(16 * (i / 16));
         n_cmp++;
         if (q_data[i] !== 8'h40 + 8'(i) || q_last[i] !== (i == 15 || i == 31 || i == 39) || q_seq[i] !== exp_seq) begin
            n_bad++;
            $display("FAIL stall_byte%0d: got d=%h l=%b s=%0d want d=%h s=%0d",
                     i, q_data[i], q_last[i], q_seq[i], 8'h40 + 8'(i), exp_seq);
         end
      end
      step();
   endtask

   task automatic test_reset_abort();
      bit ok;
      m_tready = 1'b0; peer_window = 32'd0;
      do_init(32'd9000);
      push(8, 8'hC0, -1, ok);
      peer_window = 32'd1000;
      repeat (3) step();
      n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL abort_pre: got tvalid %b want 1", m_tvalid); end
      rst = 1'b1;
      #1;
      n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL abort_tvalid: got %b want 0", m_tvalid); end
      n_cmp++; if (snd_nxt !== 32'd0) begin n_bad++; $display("FAIL abort_snd_nxt: got %0d want 0", snd_nxt); end
      n_cmp++; if (free_bytes !== 32'd64) begin n_bad++; $display("FAIL abort_free: got %0d want 64", free_bytes); end
      step();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_segmentation();
      test_full_ack();
      test_retransmit();
      test_wrap();
      test_window_tlast();
      test_stall();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tcp_tx_retransmit_buffer.md
TCP_TX_RETRANSMIT_BUFFER -- requirements
Module: tcp_tx_retransmit_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of both streams.
REQ-002 SHALL have parameter DEPTH, default 64, buffer bytes; power of two.
REQ-003 SHALL have parameter SEQ_BITS, default 32, sequence number width.
REQ-004 SHALL have parameter MSS, default 16, max bytes per emitted segment.
REQ-005 SHALL have parameter RTO_CYCLES, default 1024, retransmit timeout in clk cycles.
REQ-006 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: s_axis_tdata in DATA_WIDTH; s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tlast in 1 (end of application push).
REQ-008 SHALL have ports: m_axis_tdata out DATA_WIDTH; m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tlast out 1 (end of segment).
REQ-009 SHALL have ports: seq_init in SEQ_BITS (ISN); init_valid in 1 (pulse); ack_in in SEQ_BITS; ack_valid in 1 (pulse); peer_window in 32 (advertised receive window).
REQ-010 SHALL have ports: seg_seq out SEQ_BITS (seq of first byte of current segment); snd_una out SEQ_BITS; snd_nxt out SEQ_BITS; free_bytes out 32; retx_count out 16.

Function
REQ-011 SHALL keep registers snd_una <= snd_nxt <= wr_seq (mod 2^SEQ_BITS); byte with seq S stored at index S mod DEPTH with its tlast flag.
REQ-012 SHALL drive free_bytes = DEPTH - (wr_seq - snd_una) and s_axis_tready = initialized && free_bytes != 0.
REQ-013 SHALL, on s_axis handshake, write {tlast, tdata} at wr_seq mod DEPTH and increment wr_seq.
REQ-014 SHALL, on init_valid, set snd_una = snd_nxt = wr_seq = seq_init, set initialized, clear timer, force FSM to IDLE, drop m_axis_tvalid next cycle; init_valid overrides all same-cycle events.
REQ-015 SHALL implement FSM IDLE, SEND; while uninitialized FSM stays IDLE.
REQ-016 IDLE -> SEND when wr_seq != snd_nxt and (snd_nxt - snd_una) < peer_window; on transition latch seg_seq = snd_nxt and L = min(MSS, wr_seq - snd_nxt, peer_window - (snd_nxt - snd_una)).
REQ-017 SHALL assert m_axis_tvalid the cycle after entering SEND with byte at snd_nxt; tdata/tlast SHALL hold stable while tvalid && !tready.
REQ-018 SHALL, on each m_axis handshake, increment snd_nxt and present next byte the following cycle (1 byte/cycle sustained).
REQ-019 SHALL assert m_axis_tlast on the L-th byte or on a byte whose stored tlast flag is set, whichever first; after that handshake FSM returns to IDLE, tvalid low at least one cycle.
REQ-020 SHALL accept ack_valid only if 0 < (ack_in - snd_una) <= (snd_nxt - snd_una) (modular); then snd_una <= ack_in, freeing space; else ignore.
REQ-021 SHALL let ACK and s_axis write in the same cycle both take effect.
REQ-022 SHALL run timer only while snd_una != snd_nxt; timer clears on accepted ACK advancing snd_una or when in-flight becomes zero.
REQ-023 SHALL, on timer reaching RTO_CYCLES while IDLE, set snd_nxt = snd_una (go-back-N), clear timer, increment retx_count (saturate at 0xFFFF); expiry during SEND SHALL be deferred until segment completes.
REQ-024 SHALL never emit a byte with seq >= wr_seq; bytes written during SEND not in latched L are not added to that segment.
REQ-025 SHALL wrap all sequence arithmetic modulo 2^SEQ_BITS and buffer indices modulo DEPTH.

Reset
REQ-026 SHALL, while rst high: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, seg_seq=0, snd_una=0, snd_nxt=0, free_bytes=DEPTH, retx_count=0, FSM IDLE, uninitialized.
REQ-027 SHALL reset mid-segment abort the segment immediately; buffer contents need not be cleared.

Verification
REQ-028 init seq_init=1000, write 20 bytes, peer_window=1000, tready=1 -> segment seg_seq=1000 of 16 bytes, then seg_seq=1016 of 4 bytes; snd_nxt=1020.
REQ-029 write 64 bytes with no ACK -> s_axis_tready=0 at free_bytes=0; ack_in=init+10 -> free_bytes=10, tready=1.
REQ-030 send 8 bytes, no ACK for RTO_CYCLES -> snd_nxt back to snd_una, same 8 bytes re-emitted with same seg_seq, retx_count=1.
REQ-031 seq_init=0xFFFFFFF8, 16 bytes -> seq wraps to 0x00000008, data intact; ack_in=0x4 accepted, ack_in=0x20 ignored.
REQ-032 peer_window=3, 10 bytes queued -> 3-byte segment, no further send until ACK; input tlast on byte 2 of new push -> segment ends at byte 2.
REQ-033 m_axis_tready toggled randomly -> tdata/tlast stable under stall, no byte lost or duplicated.
